// File: rtl/ring_rr_arbiter_if.sv
// Request/grant bundle between N requesters and the ring arbiter.
interface ring_rr_arbiter_if #(
  parameter int N   = 4,
  parameter int IDW = 2
);
  logic [N-1:0]   req;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           busy;
  logic           timeout;

  modport master (
    output req,
    input  grant, grant_id, busy, timeout
  );

  modport slave (
    input  req,
    output grant, grant_id, busy, timeout
  );
endinterface

// File: rtl/ring_rr_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority token,
// a mandatory one-cycle turnaround gap and a hold timeout.
module ring_rr_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = 2,
  parameter int MAX_HOLD = 8,
  parameter int HOLD_W   = 4
) (
  input logic             clk,
  input logic             rst,
  ring_rr_arbiter_if.slave bus
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [N-1:0] ONE = N'(1);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(MAX_HOLD == 0 ? 0 : MAX_HOLD - 1);

  state_e            state_q, state_d;
  logic [N-1:0]      grant_q, grant_d;
  logic [N-1:0]      token_q, token_d;
  logic [IDW-1:0]    id_q, id_d;
  logic              busy_q, busy_d;
  logic              tmo_q, tmo_d;
  logic [HOLD_W-1:0] hold_q, hold_d;

  logic [N-1:0]   mask_hi;
  logic [N-1:0]   req_hi;
  logic [N-1:0]   pick;
  logic [N-1:0]   win_oh;
  logic [IDW-1:0] win_id;
  logic           own_req;
  logic           hit_max;

  // Bits at or above the token win first; otherwise wrap to bit 0.
  always_comb begin
    mask_hi = ~(token_q - ONE);
    req_hi  = bus.req & mask_hi;
    pick    = (|req_hi) ? req_hi : bus.req;
    win_oh  = pick & (~pick + ONE);
    win_id  = '0;
    for (int i = 0; i < N; i++) begin
      if (win_oh[i]) win_id = IDW'(i);
    end
  end

  assign own_req = |(bus.req & grant_q);
  assign hit_max = (MAX_HOLD != 0) && (hold_q == HOLD_LAST);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    token_d = token_q;
    id_d    = id_q;
    busy_d  = busy_q;
    tmo_d   = 1'b0;
    hold_d  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          grant_d = win_oh;
          id_d    = win_id;
          busy_d  = 1'b1;
          hold_d  = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!own_req || hit_max) begin
          grant_d = '0;
          id_d    = '0;
          busy_d  = 1'b0;
          hold_d  = '0;
          token_d = {grant_q[N-2:0], grant_q[N-1]};
          tmo_d   = own_req & hit_max;
          state_d = IDLE;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      token_q <= ONE;
      id_q    <= '0;
      busy_q  <= 1'b0;
      tmo_q   <= 1'b0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      token_q <= token_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
      tmo_q   <= tmo_d;
      hold_q  <= hold_d;
    end
  end

  assign bus.grant    = grant_q;
  assign bus.grant_id = id_q;
  assign bus.busy     = busy_q;
  assign bus.timeout  = tmo_q;

endmodule

// File: tb/tb_ring_rr_arbiter.sv
// Randomised and directed bench for ring_rr_arbiter against
// an index-based round-robin reference model.
module tb_ring_rr_arbiter;

  localparam int N        = 4;
  localparam int IDW      = 2;
  localparam int MAX_HOLD = 8;

  logic clk;
  logic rst;

  ring_rr_arbiter_if #(.N(N), .IDW(IDW)) bus ();

  ring_rr_arbiter #(
    .N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD), .HOLD_W(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Model: winner index (-1 = idle), token position, hold cycles.
  int m_win = -1;
  int m_tok = 0;
  int m_hold = 0;
  bit m_tmo = 1'b0;
  int tmo_seen = 0;

  task automatic model_edge(input logic [N-1:0] r, input bit rs);
    if (rs) begin
      m_win = -1; m_tok = 0; m_hold = 0; m_tmo = 1'b0;
    end else if (m_win < 0) begin
      m_tmo = 1'b0;
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_tok + k) % N;
        if (m_win < 0 && r[j]) m_win = j;
      end
      m_hold = 0;
    end else begin
      bit own;
      own = r[m_win];
      if (!own || m_hold == MAX_HOLD - 1) begin
        m_tmo = own;
        m_tok = (m_win + 1) % N;
        m_win = -1;
        m_hold = 0;
      end else begin
        m_hold++;
        m_tmo = 1'b0;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0]   eg;
    logic [IDW-1:0] ei;
    eg = (m_win < 0) ? '0 : (N'(1) << m_win);
    ei = (m_win < 0) ? '0 : IDW'(m_win);
    tests++;
    assert (bus.grant === eg) else begin
      fails++;
      $error("FAIL %s grant got %b want %b", tag, bus.grant, eg);
    end
    tests++;
    assert (bus.grant_id === ei) else begin
      fails++;
      $error("FAIL %s grant_id got %0d want %0d", tag, bus.grant_id, ei);
    end
    tests++;
    assert (bus.busy === (m_win >= 0)) else begin
      fails++;
      $error("FAIL %s busy got %b want %b", tag, bus.busy, m_win >= 0);
    end
    tests++;
    assert (bus.timeout === m_tmo) else begin
      fails++;
      $error("FAIL %s timeout got %b want %b", tag, bus.timeout, m_tmo);
    end
    if (bus.timeout === 1'b1) tmo_seen++;
  endtask

  task automatic step(input logic [N-1:0] r, input bit rs, input string tag);
    bus.req = r;
    rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic dir(input string tag, input logic [N-1:0] got,
                     input logic [N-1:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got %b want %b", tag, got, want);
    end
  endtask

  logic [N-1:0] r;

  initial begin
    bus.req = '0;
    rst = 1'b1;
    @(negedge clk);

    // Reset held with every requester active.
    step(4'b1111, 1'b1, "reset");
    step(4'b1111, 1'b1, "reset");
    step(4'b1111, 1'b0, "first");
    dir("first_grant", bus.grant, 4'b0001);

    // Rotation: each winner drops after two grant cycles.
    for (int c = 0; c < 16; c++) begin
      r = 4'b1111;
      if (m_win >= 0 && m_hold == 1) r[m_win] = 1'b0;
      step(r, 1'b0, "rotate");
    end

    // Wrap and skip: token left at bit 2, only bits 0/1 request.
    step(4'b0000, 1'b1, "rst");
    step(4'b0010, 1'b0, "wrap_a");
    dir("wrap_g1", bus.grant, 4'b0010);
    step(4'b0000, 1'b0, "wrap_b");
    step(4'b0011, 1'b0, "wrap_c");
    dir("wrap_g0", bus.grant, 4'b0001);

    // Single requester held: timeout, gap, re-grant.
    step(4'b0000, 1'b1, "rst");
    tmo_seen = 0;
    for (int c = 0; c < 30; c++) step(4'b0100, 1'b0, "hold");
    tests++;
    assert (tmo_seen == 3) else begin
      fails++;
      $error("FAIL hold_pulses got %0d want 3", tmo_seen);
    end

    // Two requesters held: alternate on timeout.
    step(4'b0000, 1'b1, "rst");
    for (int c = 0; c < 40; c++) step(4'b0101, 1'b0, "fair");

    // Reset mid-grant, then token back at bit 0.
    step(4'b0000, 1'b1, "rst");
    for (int c = 0; c < 4; c++) step(4'b0010, 1'b0, "mid");
    dir("mid_active", bus.grant, 4'b0010);
    step(4'b0010, 1'b1, "mid_rst");
    dir("mid_tmo", {3'b000, bus.timeout}, 4'b0000);
    step(4'b1010, 1'b0, "post_rst");
    dir("post_rst_g", bus.grant, 4'b0010);

    // Randomised traffic with sticky requests and rare resets.
    r = '0;
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(5) == 0) r = 4'($urandom);
      step(r, ($urandom_range(60) == 0), "rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ring_rr_arbiter.md
Name: ring_rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters.
- Priority rotates through a one-hot ring token, the same structure as the team's 4-bit ring counter.
- The token advances one position past each winner, giving starvation-free fair access.
- A hold timeout stops a single requester from monopolising the resource.

Parameters:
N, 4, number of requesters (≥2)
IDW, 2, width of grant_id; must satisfy 2**IDW ≥ N
MAX_HOLD, 8, maximum consecutive grant cycles per winner; 0 disables the timeout
HOLD_W, 4, width of the hold counter; must satisfy 2**HOLD_W ≥ MAX_HOLD

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  synchronous, active-high reset
req  input  N  request vector; bit i high = requester i wants the resource
grant  output  N  one-hot grant, registered; all-zero when idle
grant_id  output  IDW  binary index of the granted requester; 0 when idle
busy  output  1  high while any grant is asserted
timeout  output  1  one-cycle pulse when a grant is force-released by MAX_HOLD

Behaviour:
- One clock. Reset is synchronous and active-high: sampled on the rising edge of clk.
- Reset values:
  - grant = 0, grant_id = 0, busy = 0, timeout = 0
  - token = 1 (bit 0 highest priority)
  - hold_cnt = 0
  - state = IDLE
- State IDLE:
  - If req == 0, stay in IDLE.
  - Otherwise select the winner: the first set req bit found scanning from the token position upward, wrapping from bit N-1 to bit 0.
  - On the next edge: load grant with the winner's one-hot value, set grant_id, busy = 1, hold_cnt = 0, go to GRANT.
  - Latency: req sampled at edge k gives grant valid after edge k (visible in cycle k+1).
- State GRANT (winner w):
  - On each edge, if req[w] == 1 and the timeout condition is false, hold the grant and increment hold_cnt.
  - Release condition: req[w] == 0, or (MAX_HOLD ≠ 0 and hold_cnt == MAX_HOLD-1 and req[w] == 1).
  - On release:
    - grant = 0, grant_id = 0, busy = 0.
    - token = winner one-hot rotated left by 1 (bit N-1 wraps to bit 0).
    - Go to IDLE.
    - timeout = 1 for that single cycle only if the release was forced by MAX_HOLD.
- After every release the arbiter spends exactly one cycle in IDLE with grant = 0 before any new grant. This bus-turnaround gap is mandatory.
- Requests from other requesters during GRANT are ignored; they are arbitrated only from IDLE.
- A forced-released requester that keeps req high competes normally. Because the token has moved past it, it gets the lowest priority.
- Single requester: re-granted after the 1-cycle gap every time, timeout or not.
- Token invariant: exactly one bit set at all times.
- Simultaneous events:
  - Release and a new req in the same cycle: the new req is evaluated in the following IDLE cycle.
  - rst during GRANT: all state returns to reset values on that edge with no timeout pulse. token returns to 1, not rotated.
- An unused req bit (X/Z) is a bench error; the RTL does not need to guard against it.

Test Plan:
- Reset: hold rst 2 cycles with req = 4'b1111 → grant = 0, busy = 0, timeout = 0 throughout reset. First grant after release of reset is 4'b0001, grant_id = 0.
- Rotation: req = 4'b1111 held, each winner drops its req after 2 grant cycles then reasserts → grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one zero-grant cycle between each.
- Wrap and skip: token at bit 2 (after grant to bit 1), req = 4'b0011 → grant 0001 (wraps past bits 2 and 3).
- Timeout: MAX_HOLD = 8, req = 4'b0100 held constant → grant = 0100 for exactly 8 cycles, timeout pulses 1 cycle at release, 1 idle cycle, then 0100 re-granted.
- Timeout fairness: req = 4'b0101 constant, MAX_HOLD = 8 → grants alternate 0001, 0100, 0001 …, each lasting 8 cycles with a timeout pulse each time.
- Reset mid-grant: grant = 0010 active with hold_cnt = 3, assert rst 1 cycle → next cycle grant = 0, timeout = 0. With req = 4'b1010 after reset, the first grant is 0010 (token back at bit 0, scan finds bit 1).
